// File: rtl/fill_cmd_scheduler_if.sv
// Host/engine-side signal bundle for fill_cmd_scheduler.
// The master is the environment (host plus fill engine); the slave is the scheduler.
interface fill_cmd_scheduler_if;
  logic        cmd_valid;
  logic [15:0] cmd_x1;
  logic [15:0] cmd_y1;
  logic [15:0] cmd_x2;
  logic [15:0] cmd_y2;
  logic        cmd_value;
  logic        cmd_ready;
  logic        fill_busy;
  logic [15:0] X1;
  logic [15:0] Y1;
  logic [15:0] X2;
  logic [15:0] Y2;
  logic        fill_value;
  logic        start_fill;

  modport master (
    output cmd_valid, cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_value, fill_busy,
    input  cmd_ready, X1, Y1, X2, Y2, fill_value, start_fill
  );

  modport slave (
    input  cmd_valid, cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_value, fill_busy,
    output cmd_ready, X1, Y1, X2, Y2, fill_value, start_fill
  );
endinterface

// File: rtl/fill_cmd_scheduler.sv
// Queues host rectangle-fill commands and issues them one at a time to the fill engine.
// Optional FILL_CLIP_EN: clamp/discard commands against the SCREEN_W x SCREEN_H screen at push.
module fill_cmd_scheduler #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fill_cmd_scheduler_if.slave   bus,
  input  logic                  err_clear,
  output logic [3:0]            pending,
  output logic                  overflow,
  output logic                  timeout_err
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]       Full   = DEPTH[AW:0];
  localparam logic [CntW-1:0]   CntMax = CntW'(TIMEOUT - 1);

  typedef struct packed {
    logic [15:0] x1;
    logic [15:0] y1;
    logic [15:0] x2;
    logic [15:0] y2;
    logic        value;
  } cmd_t;

  typedef enum logic [2:0] {StIdle, StLoad, StIssue, StWaitB, StWaitD} state_e;

  cmd_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [15:0]     x1_q, y1_q, x2_q, y2_q;
  logic            value_q, start_q, overflow_q, timeout_q;

  cmd_t norm;
  logic keep, full, push, drop, pop;
  logic [4:0] count_ext;

  always_comb begin
    norm       = '0;
    norm.x1    = (bus.cmd_x1 < bus.cmd_x2) ? bus.cmd_x1 : bus.cmd_x2;
    norm.x2    = (bus.cmd_x1 < bus.cmd_x2) ? bus.cmd_x2 : bus.cmd_x1;
    norm.y1    = (bus.cmd_y1 < bus.cmd_y2) ? bus.cmd_y1 : bus.cmd_y2;
    norm.y2    = (bus.cmd_y1 < bus.cmd_y2) ? bus.cmd_y2 : bus.cmd_y1;
    norm.value = bus.cmd_value;
    keep       = 1'b1;
`ifdef FILL_CLIP_EN
    if (32'(norm.x2) > SCREEN_W - 1) norm.x2 = 16'(SCREEN_W - 1);
    if (32'(norm.y2) > SCREEN_H - 1) norm.y2 = 16'(SCREEN_H - 1);
    // Fully off-screen commands vanish without touching the FIFO or the overflow flag.
    keep = (32'(norm.x1) < SCREEN_W) && (32'(norm.y1) < SCREEN_H);
`endif
  end

`ifndef FILL_CLIP_EN
  logic [31:0] unused_screen;
  assign unused_screen = SCREEN_W ^ SCREEN_H;
`endif

  assign full = (count_q == Full);
  assign push = bus.cmd_valid && !full && keep;
  assign drop = bus.cmd_valid && full && keep;
  assign pop  = (state_q == StLoad);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= norm;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      x2_q       <= '0;
      y2_q       <= '0;
      value_q    <= 1'b0;
      start_q    <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
      if (drop) overflow_q <= 1'b1;
      start_q <= 1'b0;
      case (state_q)
        StIdle: if (count_q != '0) state_q <= StLoad;
        StLoad: begin
          x1_q    <= mem_q[rd_ptr_q].x1;
          y1_q    <= mem_q[rd_ptr_q].y1;
          x2_q    <= mem_q[rd_ptr_q].x2;
          y2_q    <= mem_q[rd_ptr_q].y2;
          value_q <= mem_q[rd_ptr_q].value;
          start_q <= 1'b1;
          state_q <= StIssue;
        end
        StIssue: begin
          cnt_q   <= '0;
          state_q <= StWaitB;
        end
        StWaitB: begin
          if (bus.fill_busy) begin
            state_q <= StWaitD;
          end else if (cnt_q == CntMax) begin
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitD: if (!bus.fill_busy) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      // Placed last so a clear wins over a set in the same cycle.
      if (err_clear) begin
        overflow_q <= 1'b0;
        timeout_q  <= 1'b0;
      end
    end
  end

  assign count_ext      = 5'(count_q);
  assign pending        = (count_ext > 5'd15) ? 4'd15 : count_ext[3:0];
  assign overflow       = overflow_q;
  assign timeout_err    = timeout_q;
  assign bus.cmd_ready  = !full;
  assign bus.X1         = x1_q;
  assign bus.Y1         = y1_q;
  assign bus.X2         = x2_q;
  assign bus.Y2         = y2_q;
  assign bus.fill_value = value_q;
  assign bus.start_fill = start_q;

endmodule

// File: tb/tb_fill_cmd_scheduler.sv
// Directed self-checking bench for fill_cmd_scheduler (default DEPTH=4, TIMEOUT=1023).
module tb_fill_cmd_scheduler;
  localparam int unsigned Depth   = 4;
  localparam int unsigned Timeout = 1023;

  logic       clk;
  logic       reset_n;
  logic       err_clear;
  logic [3:0] pending;
  logic       overflow;
  logic       timeout_err;

  fill_cmd_scheduler_if bus ();

  fill_cmd_scheduler #(
    .DEPTH   (Depth),
    .TIMEOUT (Timeout)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .err_clear   (err_clear),
    .pending     (pending),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Every issued command {X1,Y1,X2,Y2,fill_value}, captured mid-cycle.
  logic [64:0] issued [$];
  always @(negedge clk)
    if (bus.start_fill) issued.push_back({bus.X1, bus.Y1, bus.X2, bus.Y2, bus.fill_value});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] x1, input logic [15:0] y1,
                      input logic [15:0] x2, input logic [15:0] y2, input logic v);
    bus.cmd_x1    = x1;
    bus.cmd_y1    = y1;
    bus.cmd_x2    = x2;
    bus.cmd_y2    = y2;
    bus.cmd_value = v;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic busy_pulse(input int n);
    tick();
    bus.fill_busy = 1'b1;
    repeat (n) tick();
    bus.fill_busy = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (bus.start_fill) break;
      tick();
    end
    check(tag, 32'(bus.start_fill), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x1"}, 32'(bus.X1), 0);
    check({tag, "_y1"}, 32'(bus.Y1), 0);
    check({tag, "_x2"}, 32'(bus.X2), 0);
    check({tag, "_y2"}, 32'(bus.Y2), 0);
    check({tag, "_val"}, 32'(bus.fill_value), 0);
    check({tag, "_start"}, 32'(bus.start_fill), 0);
    check({tag, "_ready"}, 32'(bus.cmd_ready), 1);
    check({tag, "_pending"}, 32'(pending), 0);
    check({tag, "_ovf"}, 32'(overflow), 0);
    check({tag, "_tmo"}, 32'(timeout_err), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [64:0] e;
    int n_before;
    reset_n       = 1'b0;
    err_clear     = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_x1    = '0;
    bus.cmd_y1    = '0;
    bus.cmd_x2    = '0;
    bus.cmd_y2    = '0;
    bus.cmd_value = 1'b0;
    bus.fill_busy = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();

    // Single command into an idle block: issue pulse in the third cycle after the push edge.
    push(16'd10, 16'd20, 16'd30, 16'd40, 1'b1);
    check("single_pending_after_push", 32'(pending), 1);
    check("single_start_c1", 32'(bus.start_fill), 0);
    tick();
    check("single_start_c2", 32'(bus.start_fill), 0);
    tick();
    check("single_start_c3", 32'(bus.start_fill), 1);
    check("single_x1", 32'(bus.X1), 10);
    check("single_y1", 32'(bus.Y1), 20);
    check("single_x2", 32'(bus.X2), 30);
    check("single_y2", 32'(bus.Y2), 40);
    check("single_val", 32'(bus.fill_value), 1);
    check("single_pending_inflight", 32'(pending), 0);
    tick();
    check("single_start_c4", 32'(bus.start_fill), 0);
    tick();
    bus.fill_busy = 1'b1;
    repeat (5) tick();
    check("single_x1_held", 32'(bus.X1), 10);
    bus.fill_busy = 1'b0;
    repeat (4) tick();
    check("single_issue_count", 32'(issued.size()), 1);
    check("single_pending_end", 32'(pending), 0);

    // Reversed corners are normalised.
    push(16'd50, 16'd60, 16'd5, 16'd6, 1'b0);
    tick();
    tick();
    check("rev_start", 32'(bus.start_fill), 1);
    check("rev_x1", 32'(bus.X1), 5);
    check("rev_y1", 32'(bus.Y1), 6);
    check("rev_x2", 32'(bus.X2), 50);
    check("rev_y2", 32'(bus.Y2), 60);
    check("rev_val", 32'(bus.fill_value), 0);
    busy_pulse(3);

    // DEPTH+2 back-to-back commands with the engine busy: one in flight, DEPTH queued, one dropped.
    bus.fill_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push(16'(i), 16'(i + 100), 16'(i + 200), 16'(i + 300), i[0]);
      if (i == 4) begin
        check("ovf_pending_full", 32'(pending), 4);
        check("ovf_ready_low", 32'(bus.cmd_ready), 0);
        check("ovf_not_yet", 32'(overflow), 0);
      end
    end
    check("ovf_set", 32'(overflow), 1);
    check("ovf_pending_hold", 32'(pending), 4);
    // Clear in the same cycle as another drop: the clear wins.
    err_clear = 1'b1;
    push(16'd99, 16'd99, 16'd99, 16'd99, 1'b1);
    err_clear = 1'b0;
    check("ovf_clear_priority", 32'(overflow), 0);
    check("ovf_issued_first", 32'(issued.size()), 3);
    bus.fill_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_start("ovf_drain_start");
      busy_pulse(2);
    end
    check("ovf_issue_count", 32'(issued.size()), 7);
    if (issued.size() == 7) begin
      for (int i = 0; i < 5; i++) begin
        e = issued[i + 2];
        check("ovf_order_x1", 32'(e[64:49]), 32'(i));
        check("ovf_order_y2", 32'(e[16:1]), 32'(i + 300));
      end
    end
    check("ovf_pending_drained", 32'(pending), 0);

    // Engine never responds: timeout flag TIMEOUT+1 cycles after the pulse, then the next command.
    push(16'd1, 16'd2, 16'd3, 16'd4, 1'b1);
    push(16'd7, 16'd8, 16'd9, 16'd10, 1'b0);
    tick();
    check("tmo_start_a", 32'(bus.start_fill), 1);
    check("tmo_a_x1", 32'(bus.X1), 1);
    repeat (Timeout) tick();
    check("tmo_not_yet", 32'(timeout_err), 0);
    tick();
    check("tmo_set", 32'(timeout_err), 1);
    tick();
    tick();
    check("tmo_start_b", 32'(bus.start_fill), 1);
    check("tmo_b_x1", 32'(bus.X1), 7);
    busy_pulse(2);
    check("tmo_sticky", 32'(timeout_err), 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("tmo_cleared", 32'(timeout_err), 0);

    // Reset while the engine is busy with two commands queued.
    push(16'd11, 16'd11, 16'd12, 16'd12, 1'b1);
    push(16'd21, 16'd21, 16'd22, 16'd22, 1'b1);
    push(16'd31, 16'd31, 16'd32, 16'd32, 1'b1);
    check("rst_start", 32'(bus.start_fill), 1);
    bus.fill_busy = 1'b1;
    tick();
    tick();
    check("rst_pending_before", 32'(pending), 2);
    reset_n = 1'b0;
    tick();
    check_reset_outputs("rst_mid");
    n_before = issued.size();
    reset_n = 1'b1;
    bus.fill_busy = 1'b0;
    repeat (10) tick();
    check("rst_no_issue", 32'(issued.size()), 32'(n_before));
    check("rst_pending_after", 32'(pending), 0);

`ifdef FILL_CLIP_EN
    push(16'd600, 16'd470, 16'd700, 16'd500, 1'b1);
    tick();
    tick();
    check("clip_start", 32'(bus.start_fill), 1);
    check("clip_x1", 32'(bus.X1), 600);
    check("clip_x2", 32'(bus.X2), 639);
    check("clip_y2", 32'(bus.Y2), 479);
    busy_pulse(2);
    n_before = issued.size();
    push(16'd700, 16'd0, 16'd800, 16'd10, 1'b1);
    check("clip_drop_pending", 32'(pending), 0);
    repeat (6) tick();
    check("clip_drop_no_issue", 32'(issued.size()), 32'(n_before));
    check("clip_drop_no_ovf", 32'(overflow), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
